// File: rtl/rmt_ingress_arbiter.sv
// Frame-level round-robin arbiter: one ingress port per frame, grant held until tlast, tagged with tid.
// Latency: 1 cycle arbitration bubble per frame; 1 cycle from ingress transfer to m_axis_tvalid.
// Backpressure: 2-entry registered skid buffer; s_axis_tready depends only on buffer occupancy.
module rmt_ingress_arbiter #(
    parameter int PORT_COUNT = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8,
    parameter int ID_WIDTH   = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
    output logic [PORT_COUNT-1:0]            s_axis_tready,
    input  logic [PORT_COUNT-1:0]            s_axis_tlast,
    input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic                             grant_valid,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic [CNT_WIDTH-1:0]             frame_count
);

    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1 + ID_WIDTH;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   pick;
    logic [ID_WIDTH-1:0]   idx;
    logic                  found;
    logic                  push, pop, gnt_last;
    logic [BEAT_W-1:0]     in_beat, out_beat, skid_beat;
    logic                  out_vld, skid_vld;

    // First requester scanning upward from the port after the last winner.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= PORT_COUNT; k++) begin
            idx = ID_WIDTH'((int'(last_grant) + k) % PORT_COUNT);
            if (!found && s_axis_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state == XFER && !skid_vld)
            s_axis_tready[grant_id] = 1'b1;
    end

    assign push     = (state == XFER) && !skid_vld && s_axis_tvalid[grant_id];
    assign gnt_last = s_axis_tlast[grant_id];
    assign pop      = out_vld && m_axis_tready;
    assign in_beat  = {s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH],
                       s_axis_tkeep[grant_id*KEEP_WIDTH +: KEEP_WIDTH],
                       s_axis_tuser[grant_id*USER_WIDTH +: USER_WIDTH],
                       gnt_last, grant_id};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = XFER;
            XFER:    if (push && gnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_grant  <= ID_WIDTH'(PORT_COUNT - 1);
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            grant_valid <= (state_nxt == XFER);
            if (state == IDLE && found)
                grant_id <= pick;
            if (push && gnt_last) begin
                last_grant  <= grant_id;
                frame_count <= frame_count + CNT_WIDTH'(1);
            end
        end
    end

    // Output register refills from the skid entry first so beat order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_beat  <= '0;
            skid_vld  <= 1'b0;
            skid_beat <= '0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_beat <= skid_beat;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= push;
                if (push)
                    out_beat <= in_beat;
            end
        end else if (push) begin
            skid_beat <= in_beat;
            skid_vld  <= 1'b1;
        end
    end

    assign m_axis_tvalid = out_vld;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tid} = out_beat;

endmodule
